imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pkg.sv | 26 ++
 rtl/imm_gen_dec.sv | 80 ++++++++
 rtl/imm_gen_pipe.sv | 96 +++++++++
 tb/tb_imm_gen_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: opcode constants and immediate format encoding
// shared by the immediate decoder and the buffered top level.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_Z    = 3'd5,
        FMT_NONE = 3'd7
    } imm_fmt_e;

endpackage

// File: rtl/imm_gen_dec.sv
// imm_gen_dec: combinational RISC-V immediate decoder.
// Define IMM_GEN_ZICSR_EN to decode SYSTEM as CSR zimm.
module imm_gen_dec
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_fmt_e        fmt,
    output logic            illegal
);

    logic [6:0]  opc;
    logic [11:0] i_imm;
    logic [11:0] s_imm;
    logic [12:0] b_imm;
    logic [20:0] j_imm;
    logic [31:0] u_imm;
    logic [4:0]  z_imm;

    assign opc   = instr[6:0];
    assign i_imm = instr[31:20];
    assign s_imm = {instr[31:25], instr[11:7]};
    assign b_imm = {instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign j_imm = {instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign z_imm = instr[19:15];

    // select format by opcode and extend the matching field
    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        unique case (1'b1)
            opc == OPC_LOAD,
            opc == OPC_OP_IMM,
            opc == OPC_JALR: begin
                fmt = FMT_I;
                imm = XLEN'($signed(i_imm));
            end
            opc == OPC_STORE: begin
                fmt = FMT_S;
                imm = XLEN'($signed(s_imm));
            end
            opc == OPC_BRANCH: begin
                fmt = FMT_B;
                imm = XLEN'($signed(b_imm));
            end
            opc == OPC_LUI,
            opc == OPC_AUIPC: begin
                fmt = FMT_U;
                imm = XLEN'($signed(u_imm));
            end
            opc == OPC_JAL: begin
                fmt = FMT_J;
                imm = XLEN'($signed(j_imm));
            end
`ifdef IMM_GEN_ZICSR_EN
            opc == OPC_SYSTEM: begin
                fmt = FMT_Z;
                imm = XLEN'(z_imm);
            end
`else
            opc == OPC_SYSTEM: begin
                illegal = 1'b1;
            end
`endif
            opc == OPC_OP: begin
                fmt = FMT_NONE;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decodes immediates and branch targets at accept
// time into a DEPTH-entry FIFO. Optional macro: IMM_GEN_ZICSR_EN.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic [XLEN-1:0] target,
    output logic [2:0]      imm_fmt,
    output logic            illegal
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] imm_mem [DEPTH];
    logic [XLEN-1:0] tgt_mem [DEPTH];
    imm_fmt_e        fmt_mem [DEPTH];
    logic            ill_mem [DEPTH];

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_ill;
    logic            push;
    logic            pop;

    imm_gen_dec #(.XLEN(XLEN)) u_dec (
        .instr   (instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign imm_ext = imm_mem[rd_ptr];
    assign target  = tgt_mem[rd_ptr];
    assign imm_fmt = fmt_mem[rd_ptr];
    assign illegal = ill_mem[rd_ptr];

    // pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // entry storage; cleared on reset so outputs read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                imm_mem[k] <= '0;
                tgt_mem[k] <= '0;
                fmt_mem[k] <= FMT_I;
                ill_mem[k] <= 1'b0;
            end
        end else if (push) begin
            imm_mem[wr_ptr] <= dec_imm;
            tgt_mem[wr_ptr] <= pc + dec_imm;
            fmt_mem[wr_ptr] <= dec_fmt;
            ill_mem[wr_ptr] <= dec_ill;
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: random and directed checks of imm_gen_pipe
// at XLEN=32/DEPTH=2 and XLEN=64/DEPTH=3 against a queue model.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] instr = '0;
    logic [63:0] pc = '0;

    logic        rdy32, ov32, ill32;
    logic [31:0] imm32, tgt32;
    logic [2:0]  fmt32;
    logic        rdy64, ov64, ill64;
    logic [63:0] imm64, tgt64;
    logic [2:0]  fmt64;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] imm;
        logic [63:0] tgt;
        logic [2:0]  fmt;
        logic        ill;
    } ent_t;

    ent_t q32[$];
    ent_t q64[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .DEPTH(2)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy32),
        .instr     (instr),
        .pc        (pc[31:0]),
        .out_valid (ov32),
        .out_ready (out_ready),
        .imm_ext   (imm32),
        .target    (tgt32),
        .imm_fmt   (fmt32),
        .illegal   (ill32)
    );

    imm_gen_pipe #(.XLEN(64), .DEPTH(3)) u_dut64 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (rdy64),
        .instr     (instr),
        .pc        (pc),
        .out_valid (ov64),
        .out_ready (out_ready),
        .imm_ext   (imm64),
        .target    (tgt64),
        .imm_fmt   (fmt64),
        .illegal   (ill64)
    );

    task automatic chk(string tag, logic [63:0] got,
                       logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // reference: immediates rebuilt with integer arithmetic
    function automatic ent_t model(logic [31:0] i,
                                   logic [63:0] p);
        ent_t   e;
        longint v;
        int     raw;
        raw   = int'(i);
        v     = 0;
        e.fmt = 3'd7;
        e.ill = 1'b0;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin
                e.fmt = 3'd0;
                v = longint'(raw >>> 20);
            end
            7'h23: begin
                e.fmt = 3'd1;
                v = longint'(raw >>> 25) * 32
                  + longint'((i >> 7) & 32'h1f);
            end
            7'h63: begin
                e.fmt = 3'd2;
                v = (i[31] ? -64'sd4096 : 64'sd0)
                  + longint'((i >> 7) & 32'h1) * 2048
                  + longint'((i >> 25) & 32'h3f) * 32
                  + longint'((i >> 8) & 32'hf) * 2;
            end
            7'h37, 7'h17: begin
                e.fmt = 3'd3;
                v = longint'(int'(i & 32'hfffff000));
            end
            7'h6f: begin
                e.fmt = 3'd4;
                v = (i[31] ? -64'sd1048576 : 64'sd0)
                  + longint'((i >> 12) & 32'hff) * 4096
                  + longint'((i >> 20) & 32'h1) * 2048
                  + longint'((i >> 21) & 32'h3ff) * 2;
            end
            7'h73: begin
`ifdef IMM_GEN_ZICSR_EN
                e.fmt = 3'd5;
                v = longint'((i >> 15) & 32'h1f);
`else
                e.ill = 1'b1;
`endif
            end
            7'h33: e.fmt = 3'd7;
            default: e.ill = 1'b1;
        endcase
        e.imm = v;
        e.tgt = p + v;
        return e;
    endfunction

    task automatic mon(string n, int depth, int size, ent_t h,
                       logic [63:0] msk, logic ov, logic rdy,
                       logic [63:0] imm, logic [63:0] tgt,
                       logic [2:0] fmt, logic ill);
        chk({n, ".out_valid"}, ov, size != 0);
        chk({n, ".in_ready"}, rdy, size < depth);
        if (size != 0) begin
            chk({n, ".imm_ext"}, imm, h.imm & msk);
            chk({n, ".target"}, tgt, h.tgt & msk);
            chk({n, ".imm_fmt"}, fmt, h.fmt);
            chk({n, ".illegal"}, ill, h.ill);
        end
    endtask

    // scoreboard for the 32-bit instance
    always @(negedge clk) begin
        ent_t h;
        bit   acc;
        if (rst_n) begin
            h = '{64'd0, 64'd0, 3'd0, 1'b0};
            if (q32.size() != 0) h = q32[0];
            mon("d32", 2, q32.size(), h, 64'hffffffff,
                ov32, rdy32, 64'(imm32), 64'(tgt32),
                fmt32, ill32);
            acc = in_valid && (q32.size() < 2);
            if (out_ready && q32.size() != 0)
                void'(q32.pop_front());
            if (acc) q32.push_back(model(instr, pc));
        end
    end

    // scoreboard for the 64-bit instance
    always @(negedge clk) begin
        ent_t h;
        bit   acc;
        if (rst_n) begin
            h = '{64'd0, 64'd0, 3'd0, 1'b0};
            if (q64.size() != 0) h = q64[0];
            mon("d64", 3, q64.size(), h, '1,
                ov64, rdy64, imm64, tgt64, fmt64, ill64);
            acc = in_valid && (q64.size() < 3);
            if (out_ready && q64.size() != 0)
                void'(q64.pop_front());
            if (acc) q64.push_back(model(instr, pc));
        end
    end

    // reset discards every buffered model entry
    always @(negedge rst_n) begin
        q32.delete();
        q64.delete();
    end

    task automatic push_one(logic [31:0] i, logic [63:0] p);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    logic [6:0] opcs [10];
    int         k;

    initial begin
        opcs = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63,
                 7'h37, 7'h17, 7'h6f, 7'h73, 7'h33};

        #1 rst_n = 1'b0;
        #1;
        chk("rst.ov32", ov32, 0);
        chk("rst.rdy32", rdy32, 1);
        chk("rst.imm32", imm32, 0);
        chk("rst.tgt32", tgt32, 0);
        chk("rst.fmt32", fmt32, 0);
        chk("rst.ill32", ill32, 0);
        chk("rst.ov64", ov64, 0);
        chk("rst.rdy64", rdy64, 1);
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst.imm32", imm32, 0);
        chk("post_rst.tgt64", tgt64, 0);

        out_ready = 1'b1;
        push_one(32'hffc12083, 64'h0);
        chk("lw.ov32", ov32, 1);
        chk("lw.imm32", imm32, 32'hfffffffc);
        chk("lw.fmt32", fmt32, 3'd0);
        chk("lw.ill32", ill32, 0);

        push_one(32'hfe000ce3, 64'h100);
        chk("beq.imm32", imm32, 32'hfffffff8);
        chk("beq.tgt32", tgt32, 32'h000000f8);
        chk("beq.fmt32", fmt32, 3'd2);
        chk("beq.tgt64", tgt64, 64'hf8);

        push_one(32'h800000b7, 64'h0);
        chk("lui.imm64", imm64, 64'hffffffff80000000);
        chk("lui.fmt64", fmt64, 3'd3);
        chk("lui.imm32", imm32, 32'h80000000);

        push_one(32'h0002d073, 64'h0);
`ifdef IMM_GEN_ZICSR_EN
        chk("csr.imm32", imm32, 5);
        chk("csr.fmt32", fmt32, 3'd5);
        chk("csr.ill32", ill32, 0);
`else
        chk("csr.imm32", imm32, 0);
        chk("csr.fmt32", fmt32, 3'd7);
        chk("csr.ill32", ill32, 1);
`endif

        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'hffc12083;
        pc        = 64'h10;
        @(posedge clk);
        #1;
        instr = 32'hfe000ce3;
        @(posedge clk);
        #1;
        instr = 32'h800000b7;
        chk("full.rdy32", rdy32, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("full.rdy32_hold", rdy32, 0);
        chk("full.head32", imm32, 32'hfffffffc);
        out_ready = 1'b1;
        k = 0;
        while ((ov32 || ov64) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain.timeout", k < 20, 1);
        chk("drain.rdy32", rdy32, 1);
        chk("drain.ov32", ov32, 0);

        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            k = $urandom_range(0, 10);
            instr = $urandom;
            if (k < 10) instr[6:0] = opcs[k];
            pc = {$urandom, $urandom};
        end

        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b1;
        instr    = 32'h00500093;
        @(posedge clk);
        #1;
        instr = 32'h0000006f;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("pre_rst.ov32", ov32, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.ov32", ov32, 0);
        chk("arst.rdy32", rdy32, 1);
        chk("arst.ov64", ov64, 0);
        chk("arst.rdy64", rdy64, 1);
        chk("arst.imm32", imm32, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        push_one(32'hffc12083, 64'h40);
        chk("after_rst.ov32", ov32, 1);
        chk("after_rst.imm32", imm32, 32'hfffffffc);
        chk("after_rst.tgt32", tgt32, 32'h3c);

        repeat (4) @(posedge clk);
        #1;
        chk("end.ov32", ov32, 0);
        chk("end.ov64", ov64, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
